// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared types, window indices and saturation helper for the Sobel gradient pipe
package sobel_pkg;

    localparam int PIX_W = 8;
    localparam int MAG_W = PIX_W + 3;

    typedef logic [PIX_W-1:0] pixel_t;
    typedef pixel_t [0:8]     window_t;

    // Row-major window positions, index 0 is top-left
    localparam int TL = 0;
    localparam int TM = 1;
    localparam int TR = 2;
    localparam int ML = 3;
    localparam int MM = 4;
    localparam int MR = 5;
    localparam int BL = 6;
    localparam int BM = 7;
    localparam int BR = 8;

    function automatic pixel_t sat_pix(input logic [MAG_W-1:0] mag);
        return (|mag[MAG_W-1:PIX_W]) ? '1 : mag[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/sobel_axis_sum.sv
// rtl/sobel_axis_sum.sv - combinational weighted axis sum a + 2b + c, two bits of growth so it never wraps
module sobel_axis_sum #(
    parameter int PIX_W = 8
) (
    input  logic [PIX_W-1:0] a,
    input  logic [PIX_W-1:0] b,
    input  logic [PIX_W-1:0] c,
    output logic [PIX_W+1:0] sum
);

    always_comb begin
        sum = {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    end

endmodule

// File: rtl/sobel_gradient_pipe.sv
// rtl/sobel_gradient_pipe.sv - 3-stage |Gx|+|Gy| Sobel magnitude pipe with per-frame pixel count
// Optional SOBEL_THRESH_EN: binarise the magnitude against the threshold port instead of saturating.
module sobel_gradient_pipe #(
    parameter int PIX_W        = sobel_pkg::PIX_W,
    parameter int FRAME_PIXELS = 62500
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] window [0:8],
`ifdef SOBEL_THRESH_EN
    input  logic [PIX_W-1:0] threshold,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_pixel,
    output logic             frame_done
);
    import sobel_pkg::*;

    localparam int SUM_W = PIX_W + 2;
    localparam int DIF_W = PIX_W + 3;
    localparam int MW    = PIX_W + 3;
    localparam int CNT_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_PIXELS - 1);

    logic             adv;
    logic             v1, v2, v3;
    logic [SUM_W-1:0] gx_p_c, gx_n_c, gy_p_c, gy_n_c;
    logic [SUM_W-1:0] gx_p_q, gx_n_q, gy_p_q, gy_n_q;
    logic signed [DIF_W-1:0] gx_d, gy_d;
    logic [DIF_W-1:0] gx_a, gy_a;
    logic [DIF_W-1:0] ax_q, ay_q;
    logic [MW-1:0]    mag;
    logic [PIX_W-1:0] pix_c;
    logic [CNT_W-1:0] cnt_q;
    logic             unused_centre;

    // The centre tap has zero weight in both kernels
    assign unused_centre = ^window[MM];

    // A stall freezes every stage, bubbles included
    assign adv       = ~v3 | out_ready;
    assign in_ready  = adv;
    assign out_valid = v3;
    assign frame_done = v3 & (cnt_q == LAST_IDX);

    sobel_axis_sum #(.PIX_W(PIX_W)) u_gx_p (
        .a(window[TR]), .b(window[MR]), .c(window[BR]), .sum(gx_p_c)
    );
    sobel_axis_sum #(.PIX_W(PIX_W)) u_gx_n (
        .a(window[TL]), .b(window[ML]), .c(window[BL]), .sum(gx_n_c)
    );
    sobel_axis_sum #(.PIX_W(PIX_W)) u_gy_p (
        .a(window[BL]), .b(window[BM]), .c(window[BR]), .sum(gy_p_c)
    );
    sobel_axis_sum #(.PIX_W(PIX_W)) u_gy_n (
        .a(window[TL]), .b(window[TM]), .c(window[TR]), .sum(gy_n_c)
    );

    always_comb begin
        gx_d = $signed({1'b0, gx_p_q}) - $signed({1'b0, gx_n_q});
        gy_d = $signed({1'b0, gy_p_q}) - $signed({1'b0, gy_n_q});
        gx_a = gx_d[DIF_W-1] ? -gx_d : gx_d;
        gy_a = gy_d[DIF_W-1] ? -gy_d : gy_d;
    end

    always_comb begin
        mag = ax_q + ay_q;
`ifdef SOBEL_THRESH_EN
        pix_c = (mag >= MW'(threshold)) ? '1 : '0;
`else
        pix_c = (|mag[MW-1:PIX_W]) ? '1 : mag[PIX_W-1:0];
`endif
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            v1     <= 1'b0;
            gx_p_q <= '0;
            gx_n_q <= '0;
            gy_p_q <= '0;
            gy_n_q <= '0;
        end else if (adv) begin
            v1     <= in_valid;
            gx_p_q <= gx_p_c;
            gx_n_q <= gx_n_c;
            gy_p_q <= gy_p_c;
            gy_n_q <= gy_n_c;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            v2   <= 1'b0;
            ax_q <= '0;
            ay_q <= '0;
        end else if (adv) begin
            v2   <= v1;
            ax_q <= gx_a;
            ay_q <= gy_a;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            v3        <= 1'b0;
            out_pixel <= '0;
        end else if (adv) begin
            v3        <= v2;
            out_pixel <= pix_c;
        end
    end

    // Count only changes on a handshake, so frame_done holds during a stall
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else if (v3 & out_ready) begin
            cnt_q <= frame_done ? '0 : cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_sobel_gradient_pipe.sv
// tb/tb_sobel_gradient_pipe.sv - randomized scoreboard bench for sobel_gradient_pipe
module tb_sobel_gradient_pipe;

    localparam int PW = 8;
    localparam int FP = 4;

    typedef int win_t [9];

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [PW-1:0] window [0:8];
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [PW-1:0] out_pixel;
    logic          frame_done;
`ifdef SOBEL_THRESH_EN
    logic [PW-1:0] threshold = 8'd1;
`endif

    int   errors = 0;
    int   checks = 0;
    int   exp_q[$];
    int   out_cnt = 0;
    int   done_cnt = 0;
    int   stall_seen = 0;
    int   last_pix = -1;
    logic last_ov = 1'b0;
    logic accepted = 1'b0;
    logic prev_hold = 1'b0;
    logic [PW-1:0] prev_pix = '0;
    logic prev_done = 1'b0;

    always #5 clk = ~clk;

    sobel_gradient_pipe #(.PIX_W(PW), .FRAME_PIXELS(FP)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .window    (window),
`ifdef SOBEL_THRESH_EN
        .threshold (threshold),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pixel (out_pixel),
        .frame_done(frame_done)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_pix(input win_t w);
        int gx, gy, m;
        gx = (w[2] + 2*w[5] + w[8]) - (w[0] + 2*w[3] + w[6]);
        gy = (w[6] + 2*w[7] + w[8]) - (w[0] + 2*w[1] + w[2]);
        m  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef SOBEL_THRESH_EN
        return (m >= int'(threshold)) ? 255 : 0;
`else
        return (m > 255) ? 255 : m;
`endif
    endfunction

    function automatic win_t fill(input int v);
        win_t w;
        for (int i = 0; i < 9; i++) w[i] = v;
        return w;
    endfunction

    function automatic win_t rand_win();
        win_t w;
        for (int i = 0; i < 9; i++)
            w[i] = ($urandom % 4 == 0) ? 255 : int'($urandom % 256);
        return w;
    endfunction

    // One clock: drive, sample at +1, score, then step past the next edge
    task automatic cycle(input logic iv, input win_t w, input logic ordy);
        in_valid  = iv;
        out_ready = ordy;
        for (int i = 0; i < 9; i++) window[i] = PW'(w[i]);
        #1;
        if (prev_hold) begin
            check("hold_pixel", int'(out_pixel), int'(prev_pix));
            check("hold_done", int'(frame_done), int'(prev_done));
        end
        check("in_ready", int'(in_ready), int'(!out_valid || ordy));
        last_ov = out_valid;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", int'(out_valid), 0);
            end else begin
                check("out_pixel", int'(out_pixel), exp_q[0]);
                check("frame_done", int'(frame_done), int'((out_cnt % FP) == FP - 1));
            end
            if (ordy) begin
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                if (frame_done) done_cnt++;
                last_pix = int'(out_pixel);
                out_cnt++;
            end
        end
        prev_hold = out_valid && !ordy;
        prev_pix  = out_pixel;
        prev_done = frame_done;
        if (!in_ready) stall_seen++;
        accepted = iv && in_ready;
        if (accepted) exp_q.push_back(ref_pix(w));
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        n_rst    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_pixel", int'(out_pixel), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_in_ready", int'(in_ready), 1);
        exp_q.delete();
        out_cnt   = 0;
        done_cnt  = 0;
        prev_hold = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input win_t w, input logic ordy);
        int n = 0;
        do begin
            cycle(1'b1, w, ordy);
            n++;
        end while (!accepted && n < 50);
        if (!accepted) check("send_timeout", n, 0);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            cycle(1'b0, fill(0), 1'b1);
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got %0d checks expected completion", checks);
        $fatal(1);
    end

    initial begin
        int lat, base, i, c;
        win_t w, bp [6];

        apply_reset();

        // Flat window: three cycles of latency, zero gradient
        cycle(1'b1, fill(100), 1'b1);
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            cycle(1'b0, fill(0), 1'b1);
            if (last_ov) begin
                lat = k;
                break;
            end
        end
        check("latency", lat, 3);
        check("flat_pixel", last_pix, 0);
        drain();

        w = fill(0);
        w[2] = 255; w[5] = 255; w[8] = 255;
        send(w, 1'b1);
        drain();
        check("vert_edge", last_pix, 255);

        w = fill(0);
        w[2] = 10; w[5] = 10; w[8] = 10;
`ifdef SOBEL_THRESH_EN
        threshold = 8'd40;
        send(w, 1'b1);
        drain();
        check("thresh_40", last_pix, 255);
        threshold = 8'd41;
        send(w, 1'b1);
        drain();
        check("thresh_41", last_pix, 0);
        threshold = 8'd100;
`else
        send(w, 1'b1);
        drain();
        check("small_grad", last_pix, 40);
`endif

        // Frame wrap: nine outputs give frame_done on the 4th and 8th
        apply_reset();
        for (int k = 0; k < 9; k++) send(rand_win(), 1'b1);
        drain();
        check("frame_outputs", out_cnt, 9);
        check("frame_done_count", done_cnt, 2);

        // Backpressure: six windows, out_ready low for cycles 2..6
        for (int k = 0; k < 6; k++) bp[k] = rand_win();
        stall_seen = 0;
        base = out_cnt;
        i = 0;
        c = 0;
        while ((i < 6 || exp_q.size() != 0) && c < 60) begin
            cycle(i < 6, (i < 6) ? bp[i] : fill(0), !(c >= 2 && c < 7));
            if (accepted) i++;
            c++;
        end
        check("bp_outputs", out_cnt - base, 6);
        check("bp_stalled", int'(stall_seen > 0), 1);

        // Random traffic with random backpressure
        i = 0;
        w = rand_win();
        for (int k = 0; k < 500; k++) begin
            cycle(($urandom % 4) != 0, w, ($urandom % 3) != 0);
            if (accepted) begin
                w = rand_win();
                i++;
            end
        end
        drain();
        check("rand_progress", int'(i > 100), 1);

        // Reset with three windows in flight
        apply_reset();
        for (int k = 0; k < 3; k++) send(rand_win(), 1'b0);
        apply_reset();
        for (int k = 0; k < 5; k++) cycle(1'b0, fill(0), 1'b1);
        check("post_rst_outputs", out_cnt, 0);
        for (int k = 0; k < FP; k++) send(rand_win(), 1'b1);
        drain();
        check("post_rst_done", done_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sobel_gradient_pipe.md
Name: sobel_gradient_pipe

Overview:
- Consumes the 3x3 pixel window produced by the window buffer stage.
- Computes the Sobel gradient magnitude approximation |Gx|+|Gy|, saturated to 8 bits, in a 3-stage registered pipeline with valid/ready handshakes on both sides.
- Counts output pixels per frame and flags the last one.
- Feeds the output pixel writer (SRAM write stage).

Parameters:
- PIX_W, 8, pixel width in bits; magnitude output uses the same width.
- FRAME_PIXELS, 62500, output pixels per frame before frame_done; minimum 1.

Ports:
- clk  input  1  clock, rising edge
- n_rst  input  1  asynchronous, active-low reset
- in_valid  input  1  window[0:8] holds a complete window
- in_ready  output  1  block accepts window this cycle
- window  input  9xPIX_W  unpacked [0:8], row-major; 0-2 top row, 3-5 middle, 6-8 bottom; index 0 top-left
- out_valid  output  1  out_pixel valid
- out_ready  input  1  downstream accepts out_pixel
- out_pixel  output  PIX_W  edge magnitude
- frame_done  output  1  high with the last pixel of a frame while out_valid
- threshold  input  PIX_W  present only with SOBEL_THRESH_EN

Behaviour:
- Reset values (async, n_rst low): all stage valid bits 0, out_valid 0, out_pixel 0, frame_done 0, pixel counter 0. Data registers cleared to 0.
- Arithmetic:
  - Gx = (w2+2w5+w8) - (w0+2w3+w6).
  - Gy = (w6+2w7+w8) - (w0+2w1+w2).
  - Partial sums are unsigned, PIX_W+2 bits (max 1020).
  - Differences are signed, PIX_W+3 bits.
  - mag = |Gx|+|Gy|, unsigned, PIX_W+3 bits (max 2040).
  - out_pixel = min(mag, 2^PIX_W-1). No wrap allowed anywhere.
- Stages:
  - S1 registers the four partial sums plus valid v1.
  - S2 registers |Gx| and |Gy| plus v2.
  - S3 registers the saturated pixel plus v3. out_valid = v3.
- Advance: adv = ~v3 | out_ready.
  - When adv=1, every stage loads from its predecessor (v1 <= in_valid & in_ready).
  - When adv=0, all stage registers hold.
  - in_ready = adv, combinational.
- Latency: a window accepted at edge N gives out_valid at edge N+3 if unstalled. Throughput is 1 window/cycle.
- Bubbles are not collapsed: a stall holds the whole pipe, including empty stages.
- Holding: while out_valid & ~out_ready, out_pixel and frame_done are stable.
- Counter:
  - Increments on each output handshake (out_valid & out_ready).
  - frame_done = out_valid & (count == FRAME_PIXELS-1).
  - A handshake with frame_done high wraps the counter to 0.
- in_valid low with in_ready high inserts a bubble; v1 becomes 0.
- Reset mid-operation discards all in-flight windows and the count. The first output after reset is pixel 0 of a new frame.
- Input window contents are don't-care when in_valid=0.

Optional Feature:
- Macro: SOBEL_THRESH_EN.
- Defined:
  - threshold port exists.
  - S3 stores out_pixel = (mag >= threshold) ? 2^PIX_W-1 : 0, comparing full-width mag against zero-extended threshold.
  - threshold is sampled at the S2->S3 transfer.
- Undefined: no threshold port; output is the saturated magnitude. Timing and handshakes are identical in both builds.

Decomposition:
- Package sobel_pkg:
  - PIX_W default.
  - typedef pixel_t (logic [PIX_W-1:0]).
  - typedef window_t (pixel_t [0:8]).
  - Window index constants (TL=0 .. BR=8).
  - MAG_W = PIX_W+3.
  - Function sat_pix(mag).
- Sub-module sobel_axis_sum, combinational: takes three pixels and returns a+2b+c. Instantiated four times in S1.

Test Plan:
- Flat window, all w=100, in_valid one cycle, out_ready=1 -> out_valid exactly 3 cycles later, out_pixel=0.
- Vertical edge: w0,w3,w6=0; w2,w5,w8=255; others 0 -> Gx=1020, Gy=255-255=0, mag saturates -> out_pixel=255.
- Small gradient: w2=w5=w8=10, others 0 -> Gx=40, Gy=0 -> out_pixel=40. With SOBEL_THRESH_EN: threshold=40 -> 255; threshold=41 -> 0.
- Backpressure: stream 6 distinct windows back-to-back, out_ready=0 from cycle 2 for 5 cycles -> in_ready falls when v3 set; out_pixel stable while stalled; all 6 outputs in order, none lost or duplicated.
- Frame wrap with FRAME_PIXELS=4: stream 9 windows -> frame_done on outputs 4 and 8 only; counter 0 after output 8.
- Reset mid-stream: assert n_rst with 3 windows in flight -> out_valid drops immediately and no stale outputs appear. Next window is counted as pixel 0; frame_done occurs on the FRAME_PIXELS-th post-reset output.
